// File: rtl/axi_pkg.sv
// Shared definitions for the AXI4 burst slave SRAM.
// Holds the burst and response encodings, the FSM state types, and the
// WRAP length legality check that the address generator uses.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_t;

    // WRAP bursts are only legal for 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Per-beat address step and error check, purely combinational.
// Ports:
//   addr      current beat byte address
//   size      log2 bytes per beat
//   len       beats-1 of the burst
//   burst     FIXED / INCR / WRAP
//   next_addr byte address of the following beat
//   beat_err  current beat must answer SLVERR
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int DW = 128,
    parameter int AW = 16
) (
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    input  logic [7:0]  len,
    input  logic [1:0]  burst,
    output logic [31:0] next_addr,
    output logic        beat_err
);

    localparam int         OFS  = $clog2(DW / 8);
    localparam int         TOP  = OFS + AW;
    localparam logic [2:0] OFS3 = 3'(OFS);

    logic [31:0] step;
    logic [31:0] incr;
    logic [31:0] wrap_mask;
    logic        oor;

    always_comb begin
        step      = 32'd1 << size;
        incr      = addr + step;
        // Window size is (len+1)<<size; only meaningful for legal WRAP lengths.
        wrap_mask = ((({24'd0, len}) + 32'd1) << size) - 32'd1;
        // Any byte-address bit above the array span is out of range.
        oor       = |(addr >> TOP);

        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
            default:     next_addr = incr;
        endcase

        beat_err = oor
                 | (size > OFS3)
                 | (burst == 2'd3)
                 | ((burst == BURST_WRAP) && !wrap_len_ok(len));
    end

endmodule

// File: rtl/axi_burst_slv_sram.sv
// AXI4 full slave backed by a 1R1W word array.
// Independent read and write FSMs; FIXED/INCR/WRAP bursts, narrow writes
// through WSTRB, ID echo, programmable read latency, SLVERR on
// out-of-range or illegal requests and on WLAST misplacement.
// Ports:
//   CLK, RSTn             clock, async active-low reset
//   MEM_AW*, MEM_W*, MEM_B*  write address / data / response channels
//   MEM_AR*, MEM_R*          read address / data channels
// The array `ram` is not reset and may be preloaded hierarchically.
module axi_burst_slv_sram
    import axi_pkg::*;
#(
    parameter int DW     = 128,
    parameter int AW     = 16,
    parameter int IW     = 1,
    parameter int RD_LAT = 1
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic [IW-1:0]   MEM_AWID,
    input  logic [31:0]     MEM_AWADDR,
    input  logic [7:0]      MEM_AWLEN,
    input  logic [2:0]      MEM_AWSIZE,
    input  logic [1:0]      MEM_AWBURST,
    input  logic            MEM_AWVALID,
    output logic            MEM_AWREADY,
    input  logic [DW-1:0]   MEM_WDATA,
    input  logic [DW/8-1:0] MEM_WSTRB,
    input  logic            MEM_WLAST,
    input  logic            MEM_WVALID,
    output logic            MEM_WREADY,
    output logic [IW-1:0]   MEM_BID,
    output logic [1:0]      MEM_BRESP,
    output logic            MEM_BVALID,
    input  logic            MEM_BREADY,
    input  logic [IW-1:0]   MEM_ARID,
    input  logic [31:0]     MEM_ARADDR,
    input  logic [7:0]      MEM_ARLEN,
    input  logic [2:0]      MEM_ARSIZE,
    input  logic [1:0]      MEM_ARBURST,
    input  logic            MEM_ARVALID,
    output logic            MEM_ARREADY,
    output logic [IW-1:0]   MEM_RID,
    output logic [DW-1:0]   MEM_RDATA,
    output logic [1:0]      MEM_RRESP,
    output logic            MEM_RLAST,
    output logic            MEM_RVALID,
    input  logic            MEM_RREADY
);

    localparam int         BW        = DW / 8;
    localparam int         OFS       = $clog2(BW);
    localparam bit         NO_WAIT   = (RD_LAT <= 1);
    localparam logic [7:0] WAIT_INIT = 8'((RD_LAT > 1) ? RD_LAT - 2 : 0);

    reg [DW-1:0] ram [0:2**AW-1];

    // ---------------------------------------------------------------- write
    wr_state_t     w_state, w_next;
    logic [IW-1:0] w_id;
    logic [31:0]   w_addr;
    logic [7:0]    w_len;
    logic [2:0]    w_size;
    logic [1:0]    w_burst;
    logic [7:0]    w_beat;
    logic          w_err;
    logic [31:0]   wg_next;
    logic          wg_err;
    logic          w_fire;
    logic [AW-1:0] w_word;

    axi_burst_addr_gen #(.DW(DW), .AW(AW)) u_wgen (
        .addr(w_addr), .size(w_size), .len(w_len), .burst(w_burst),
        .next_addr(wg_next), .beat_err(wg_err)
    );

    assign w_fire = (w_state == W_DATA) && MEM_WVALID;
    assign w_word = w_addr[OFS+AW-1:OFS];

    always_ff @(posedge CLK or negedge RSTn)
        if (!RSTn) w_state <= W_IDLE;
        else       w_state <= w_next;

    always_comb begin
        w_next      = w_state;
        // READY is forced low while reset is held, not only after it.
        MEM_AWREADY = (w_state == W_IDLE) && RSTn;
        MEM_WREADY  = (w_state == W_DATA);
        MEM_BVALID  = (w_state == W_RESP);
        MEM_BID     = w_id;
        MEM_BRESP   = w_err ? RESP_SLVERR : RESP_OKAY;
        case (w_state)
            W_IDLE: if (MEM_AWVALID)                  w_next = W_DATA;
            W_DATA: if (MEM_WVALID && w_beat == w_len) w_next = W_RESP;
            W_RESP: if (MEM_BREADY)                   w_next = W_IDLE;
            default:                                  w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_beat  <= '0;
            w_err   <= 1'b0;
        end else begin
            if (w_state == W_IDLE && MEM_AWVALID) begin
                w_id    <= MEM_AWID;
                w_addr  <= MEM_AWADDR;
                w_len   <= MEM_AWLEN;
                w_size  <= MEM_AWSIZE;
                w_burst <= MEM_AWBURST;
                w_beat  <= '0;
                w_err   <= 1'b0;
            end
            if (w_fire) begin
                w_addr <= wg_next;
                w_beat <= w_beat + 8'd1;
                // WLAST is only checked; the beat count ends the burst.
                if (wg_err || (MEM_WLAST != (w_beat == w_len)))
                    w_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK)
        if (w_fire && !wg_err)
            for (int b = 0; b < BW; b++)
                if (MEM_WSTRB[b]) ram[w_word][8*b +: 8] <= MEM_WDATA[8*b +: 8];

    // ----------------------------------------------------------------- read
    rd_state_t     r_state, r_next;
    logic [IW-1:0] r_id;
    logic [31:0]   r_addr;
    logic [7:0]    r_len;
    logic [2:0]    r_size;
    logic [1:0]    r_burst;
    logic [7:0]    r_beat;
    logic [7:0]    r_cnt;
    logic [DW-1:0] r_data;
    logic [1:0]    r_resp;
    logic          r_last;

    // In R_IDLE the generator looks at the AR inputs directly so that a
    // zero-wait read can fetch beat 0 on the handshake edge.
    logic          r_idle;
    logic [31:0]   ra_addr;
    logic [7:0]    ra_len;
    logic [2:0]    ra_size;
    logic [1:0]    ra_burst;
    logic [7:0]    ra_beat;
    logic [31:0]   rg_next;
    logic          rg_err;
    logic          r_load;
    logic [AW-1:0] r_word;

    assign r_idle   = (r_state == R_IDLE);
    assign ra_addr  = r_idle ? MEM_ARADDR  : r_addr;
    assign ra_len   = r_idle ? MEM_ARLEN   : r_len;
    assign ra_size  = r_idle ? MEM_ARSIZE  : r_size;
    assign ra_burst = r_idle ? MEM_ARBURST : r_burst;
    assign ra_beat  = r_idle ? 8'd0        : r_beat;
    assign r_word   = ra_addr[OFS+AW-1:OFS];

    axi_burst_addr_gen #(.DW(DW), .AW(AW)) u_rgen (
        .addr(ra_addr), .size(ra_size), .len(ra_len), .burst(ra_burst),
        .next_addr(rg_next), .beat_err(rg_err)
    );

    // A beat is fetched when it becomes the presented one.
    assign r_load = (r_idle && MEM_ARVALID && NO_WAIT)
                  || (r_state == R_WAIT && r_cnt == 8'd0)
                  || (r_state == R_DATA && MEM_RREADY && !r_last);

    always_ff @(posedge CLK or negedge RSTn)
        if (!RSTn) r_state <= R_IDLE;
        else       r_state <= r_next;

    always_comb begin
        r_next      = r_state;
        MEM_ARREADY = r_idle && RSTn;
        MEM_RVALID  = (r_state == R_DATA);
        MEM_RID     = r_id;
        MEM_RDATA   = r_data;
        MEM_RRESP   = r_resp;
        MEM_RLAST   = r_last;
        case (r_state)
            R_IDLE: if (MEM_ARVALID)              r_next = NO_WAIT ? R_DATA : R_WAIT;
            R_WAIT: if (r_cnt == 8'd0)            r_next = R_DATA;
            R_DATA: if (MEM_RREADY && r_last)     r_next = R_IDLE;
            default:                              r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_beat  <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_resp  <= RESP_OKAY;
            r_last  <= 1'b0;
        end else begin
            if (r_idle && MEM_ARVALID) begin
                r_id    <= MEM_ARID;
                r_addr  <= MEM_ARADDR;
                r_len   <= MEM_ARLEN;
                r_size  <= MEM_ARSIZE;
                r_burst <= MEM_ARBURST;
                r_beat  <= '0;
                r_cnt   <= WAIT_INIT;
            end
            if (r_state == R_WAIT && r_cnt != 8'd0)
                r_cnt <= r_cnt - 8'd1;
            if (r_load) begin
                // Non-blocking read of ram: a same-edge write is not visible.
                r_data <= rg_err ? '0 : ram[r_word];
                r_resp <= rg_err ? RESP_SLVERR : RESP_OKAY;
                r_last <= (ra_beat == ra_len);
                r_addr <= rg_next;
                r_beat <= ra_beat + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_axi_burst_slv_sram.sv
module tb_axi_burst_slv_sram;

    localparam int DW = 128;
    localparam int IW = 1;
    localparam int BW = DW / 8;

    logic CLK = 1'b0;
    logic RSTn = 1'b0;
    always #5 CLK = ~CLK;

    // main DUT, RD_LAT = 1
    logic [IW-1:0] AWID, ARID, BID, RID;
    logic [31:0]   AWADDR, ARADDR;
    logic [7:0]    AWLEN, ARLEN;
    logic [2:0]    AWSIZE, ARSIZE;
    logic [1:0]    AWBURST, ARBURST, BRESP, RRESP;
    logic          AWVALID, AWREADY, ARVALID, ARREADY;
    logic [DW-1:0] WDATA, RDATA;
    logic [BW-1:0] WSTRB;
    logic          WLAST, WVALID, WREADY, BVALID, BREADY, RLAST, RVALID, RREADY;

    // latency DUT, RD_LAT = 4; write channel idle
    logic [IW-1:0] l_BID, l_RID, l_ARID;
    logic [31:0]   l_ARADDR;
    logic [7:0]    l_ARLEN;
    logic [2:0]    l_ARSIZE;
    logic [1:0]    l_ARBURST, l_BRESP, l_RRESP;
    logic          l_AWREADY, l_WREADY, l_BVALID, l_ARVALID, l_ARREADY;
    logic [DW-1:0] l_RDATA;
    logic          l_RLAST, l_RVALID, l_RREADY;

    int checks = 0;
    int errors = 0;

    axi_burst_slv_sram #(.DW(DW), .AW(16), .IW(IW), .RD_LAT(1)) u_dut (
        .CLK(CLK), .RSTn(RSTn),
        .MEM_AWID(AWID), .MEM_AWADDR(AWADDR), .MEM_AWLEN(AWLEN), .MEM_AWSIZE(AWSIZE),
        .MEM_AWBURST(AWBURST), .MEM_AWVALID(AWVALID), .MEM_AWREADY(AWREADY),
        .MEM_WDATA(WDATA), .MEM_WSTRB(WSTRB), .MEM_WLAST(WLAST), .MEM_WVALID(WVALID),
        .MEM_WREADY(WREADY), .MEM_BID(BID), .MEM_BRESP(BRESP), .MEM_BVALID(BVALID),
        .MEM_BREADY(BREADY), .MEM_ARID(ARID), .MEM_ARADDR(ARADDR), .MEM_ARLEN(ARLEN),
        .MEM_ARSIZE(ARSIZE), .MEM_ARBURST(ARBURST), .MEM_ARVALID(ARVALID),
        .MEM_ARREADY(ARREADY), .MEM_RID(RID), .MEM_RDATA(RDATA), .MEM_RRESP(RRESP),
        .MEM_RLAST(RLAST), .MEM_RVALID(RVALID), .MEM_RREADY(RREADY)
    );

    axi_burst_slv_sram #(.DW(DW), .AW(16), .IW(IW), .RD_LAT(4)) u_lat (
        .CLK(CLK), .RSTn(RSTn),
        .MEM_AWID('0), .MEM_AWADDR(32'd0), .MEM_AWLEN(8'd0), .MEM_AWSIZE(3'd0),
        .MEM_AWBURST(2'd0), .MEM_AWVALID(1'b0), .MEM_AWREADY(l_AWREADY),
        .MEM_WDATA('0), .MEM_WSTRB('0), .MEM_WLAST(1'b0), .MEM_WVALID(1'b0),
        .MEM_WREADY(l_WREADY), .MEM_BID(l_BID), .MEM_BRESP(l_BRESP), .MEM_BVALID(l_BVALID),
        .MEM_BREADY(1'b0), .MEM_ARID(l_ARID), .MEM_ARADDR(l_ARADDR), .MEM_ARLEN(l_ARLEN),
        .MEM_ARSIZE(l_ARSIZE), .MEM_ARBURST(l_ARBURST), .MEM_ARVALID(l_ARVALID),
        .MEM_ARREADY(l_ARREADY), .MEM_RID(l_RID), .MEM_RDATA(l_RDATA), .MEM_RRESP(l_RRESP),
        .MEM_RLAST(l_RLAST), .MEM_RVALID(l_RVALID), .MEM_RREADY(l_RREADY)
    );

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // ---------------------------------------------------------- drivers
    task automatic aw_req(input logic [IW-1:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        while (!AWREADY && n < 50) begin tick; n++; end
        if (!AWREADY) begin errors++; $display("FAIL aw_timeout awready=%0b required 1", AWREADY); end
        tick;
        AWVALID = 1'b0;
    endtask

    task automatic w_send(input logic [DW-1:0] data, input logic [BW-1:0] strb, input logic last);
        int n = 0;
        WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1;
        while (!WREADY && n < 50) begin tick; n++; end
        if (!WREADY) begin errors++; $display("FAIL w_timeout wready=%0b required 1", WREADY); end
        tick;
        WVALID = 1'b0; WLAST = 1'b0;
    endtask

    task automatic b_get(output logic [1:0] resp, output logic [IW-1:0] id);
        int n = 0;
        BREADY = 1'b1;
        while (!BVALID && n < 50) begin tick; n++; end
        if (!BVALID) begin errors++; $display("FAIL b_timeout bvalid=%0b required 1", BVALID); end
        resp = BRESP; id = BID;
        tick;
        BREADY = 1'b0;
    endtask

    task automatic ar_req(input logic [IW-1:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
        while (!ARREADY && n < 50) begin tick; n++; end
        if (!ARREADY) begin errors++; $display("FAIL ar_timeout arready=%0b required 1", ARREADY); end
        tick;
        ARVALID = 1'b0;
    endtask

    task automatic r_get(output logic [DW-1:0] data, output logic [1:0] resp,
                         output logic last, output logic [IW-1:0] id);
        int n = 0;
        RREADY = 1'b1;
        while (!RVALID && n < 50) begin tick; n++; end
        if (!RVALID) begin errors++; $display("FAIL r_timeout rvalid=%0b required 1", RVALID); end
        data = RDATA; resp = RRESP; last = RLAST; id = RID;
        tick;
        RREADY = 1'b0;
    endtask

    function automatic logic [DW-1:0] pat(input int i);
        return {4{32'hC0DE_0000 + 32'(i)}};
    endfunction

    // ------------------------------------------------------------ tests
    task automatic test_reset;
        RSTn = 1'b0;
        tick; tick;
        checks++;
        if ({AWREADY, WREADY, BVALID, ARREADY, RVALID} !== 5'b0) begin
            errors++; $display("FAIL reset_handshake got %b required 00000",
                               {AWREADY, WREADY, BVALID, ARREADY, RVALID});
        end
        checks++;
        if (RDATA !== '0 || RRESP !== 2'b00 || BRESP !== 2'b00 || RID !== '0 || BID !== '0) begin
            errors++; $display("FAIL reset_data rdata=%h rresp=%b bresp=%b required zeros", RDATA, RRESP, BRESP);
        end
        RSTn = 1'b1;
        #1;
        checks++;
        if (AWREADY !== 1'b1 || ARREADY !== 1'b1 || l_ARREADY !== 1'b1) begin
            errors++; $display("FAIL reset_release awready=%b arready=%b l_arready=%b required 1",
                               AWREADY, ARREADY, l_ARREADY);
        end
        tick;
    endtask

    task automatic test_incr;
        logic [1:0] resp; logic [IW-1:0] id; logic [DW-1:0] d; logic last;
        aw_req(1'b0, 32'h100, 8'd3, 3'd4, 2'd1);
        for (int i = 0; i < 4; i++) w_send(pat(i), '1, (i == 3));
        b_get(resp, id);
        checks++;
        if (resp !== 2'b00 || id !== 1'b0) begin
            errors++; $display("FAIL incr_bresp got resp=%b id=%b required 00 0", resp, id);
        end
        ar_req(1'b1, 32'h100, 8'd3, 3'd4, 2'd1);
        for (int i = 0; i < 4; i++) begin
            r_get(d, resp, last, id);
            checks++;
            if (d !== pat(i) || resp !== 2'b00 || last !== (i == 3) || id !== 1'b1) begin
                errors++; $display("FAIL incr_rbeat%0d got %h resp=%b last=%b id=%b required %h 00 %0b 1",
                                   i, d, resp, last, id, pat(i), (i == 3));
            end
        end
    endtask

    task automatic test_wrap;
        logic [1:0] resp; logic [IW-1:0] id; logic [DW-1:0] d; logic last;
        logic [DW-1:0] exp_d [4];
        for (int i = 0; i < 4; i++) u_dut.ram[16 + i] = DW'(i);
        exp_d[0] = 128'd3; exp_d[1] = 128'd0; exp_d[2] = 128'd1; exp_d[3] = 128'd2;
        ar_req(1'b0, 32'h130, 8'd3, 3'd4, 2'd2);
        for (int i = 0; i < 4; i++) begin
            r_get(d, resp, last, id);
            checks++;
            if (d !== exp_d[i] || resp !== 2'b00 || last !== (i == 3)) begin
                errors++; $display("FAIL wrap_beat%0d got %h resp=%b last=%b required %h 00 %0b",
                                   i, d, resp, last, exp_d[i], (i == 3));
            end
        end
    endtask

    task automatic test_narrow;
        logic [1:0] resp; logic [IW-1:0] id;
        logic [DW-1:0] expv;
        u_dut.ram[0] = '1;
        expv = 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_FFFF_FFFF;
        aw_req(1'b1, 32'h4, 8'd0, 3'd2, 2'd1);
        w_send('0, 16'h00F0, 1'b1);
        b_get(resp, id);
        checks++;
        if (resp !== 2'b00 || id !== 1'b1) begin
            errors++; $display("FAIL narrow_bresp got resp=%b id=%b required 00 1", resp, id);
        end
        checks++;
        if (u_dut.ram[0] !== expv) begin
            errors++; $display("FAIL narrow_word got %h required %h", u_dut.ram[0], expv);
        end
    endtask

    task automatic test_oor;
        logic [1:0] resp; logic [IW-1:0] id; logic [DW-1:0] d; logic last;
        logic [DW-1:0] k;
        k = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        u_dut.ram[0] = k;
        aw_req(1'b0, 32'h0010_0000, 8'd0, 3'd4, 2'd1);
        w_send({32{4'h5}}, '1, 1'b1);
        b_get(resp, id);
        checks++;
        if (resp !== 2'b10) begin errors++; $display("FAIL oor_bresp got %b required 10", resp); end
        checks++;
        if (u_dut.ram[0] !== k) begin errors++; $display("FAIL oor_array got %h required %h", u_dut.ram[0], k); end
        ar_req(1'b0, 32'h0010_0000, 8'd0, 3'd4, 2'd1);
        r_get(d, resp, last, id);
        checks++;
        if (d !== '0 || resp !== 2'b10 || last !== 1'b1) begin
            errors++; $display("FAIL oor_read got %h resp=%b last=%b required 0 10 1", d, resp, last);
        end
    endtask

    task automatic test_wlast;
        logic [1:0] resp; logic [IW-1:0] id;
        aw_req(1'b1, 32'h200, 8'd3, 3'd4, 2'd1);
        for (int i = 0; i < 4; i++) w_send(pat(10 + i), '1, (i == 1));
        b_get(resp, id);
        checks++;
        if (resp !== 2'b10 || id !== 1'b1) begin
            errors++; $display("FAIL wlast_bresp got resp=%b id=%b required 10 1", resp, id);
        end
        checks++;
        if (u_dut.ram[35] !== pat(13)) begin
            errors++; $display("FAIL wlast_beat3 got %h required %h", u_dut.ram[35], pat(13));
        end
    endtask

    task automatic test_latency;
        int n = 0;
        logic [DW-1:0] v0, v1;
        v0 = pat(100); v1 = pat(101);
        u_lat.ram[2] = v0; u_lat.ram[3] = v1;
        l_ARID = 1'b1; l_ARADDR = 32'h20; l_ARLEN = 8'd1; l_ARSIZE = 3'd4; l_ARBURST = 2'd1;
        l_RREADY = 1'b0; l_ARVALID = 1'b1;
        tick;                                   // handshake edge
        l_ARVALID = 1'b0;
        while (!l_RVALID && n < 20) begin tick; n++; end
        checks++;
        if (n !== 3) begin errors++; $display("FAIL lat_rvalid edges=%0d required 3", n); end
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (l_RVALID !== 1'b1 || l_RDATA !== v0 || l_RLAST !== 1'b0 || l_RID !== 1'b1) begin
                errors++; $display("FAIL lat_stall%0d got v=%b d=%h last=%b required 1 %h 0",
                                   s, l_RVALID, l_RDATA, l_RLAST, v0);
            end
            tick;
        end
        l_RREADY = 1'b1;
        tick;
        checks++;
        if (l_RVALID !== 1'b1 || l_RDATA !== v1 || l_RLAST !== 1'b1 || l_RRESP !== 2'b00) begin
            errors++; $display("FAIL lat_beat1 got v=%b d=%h last=%b resp=%b required 1 %h 1 00",
                               l_RVALID, l_RDATA, l_RLAST, l_RRESP, v1);
        end
        tick;
        l_RREADY = 1'b0;
        checks++;
        if (l_RVALID !== 1'b0 || l_ARREADY !== 1'b1) begin
            errors++; $display("FAIL lat_done got rvalid=%b arready=%b required 0 1", l_RVALID, l_ARREADY);
        end
    endtask

    task automatic test_reset_mid;
        logic [1:0] resp; logic [IW-1:0] id; logic [DW-1:0] d; logic last;
        ar_req(1'b0, 32'h100, 8'd3, 3'd4, 2'd1);
        r_get(d, resp, last, id);
        checks++;
        if (RVALID !== 1'b1) begin errors++; $display("FAIL mid_pending rvalid=%b required 1", RVALID); end
        RSTn = 1'b0;
        #1;
        checks++;
        if (RVALID !== 1'b0 || ARREADY !== 1'b0) begin
            errors++; $display("FAIL mid_reset got rvalid=%b arready=%b required 0 0", RVALID, ARREADY);
        end
        tick;
        checks++;
        if (RVALID !== 1'b0 || ARREADY !== 1'b0 || RDATA !== '0) begin
            errors++; $display("FAIL mid_reset_hold got rvalid=%b arready=%b rdata=%h required 0 0 0",
                               RVALID, ARREADY, RDATA);
        end
        RSTn = 1'b1;
        #1;
        checks++;
        if (ARREADY !== 1'b1 || RVALID !== 1'b0) begin
            errors++; $display("FAIL mid_release got arready=%b rvalid=%b required 1 0", ARREADY, RVALID);
        end
        tick;
    endtask

    initial begin
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0; RREADY = 1'b0;
        l_ARID = '0; l_ARADDR = '0; l_ARLEN = '0; l_ARSIZE = '0; l_ARBURST = '0;
        l_ARVALID = 1'b0; l_RREADY = 1'b0;
        test_reset;
        test_incr;
        test_wrap;
        test_narrow;
        test_oor;
        test_wlast;
        test_latency;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
